// File: rtl/rcb_host_arb_if.sv
// -----------------------------------------------------------------------------
// rcb_host_arb_if
//   Bundles the three buses around one RCB RAM arbiter: the pipeline read
//   channel, the host read/write channel and the single-port RAM port.
//
//   Modports
//     slave  : the arbiter. Takes requests and RAM read data; drives readies,
//              responses and the RAM command.
//     master : the surroundings (pipeline, host_if and RAM). Mirror image of
//              slave.
//
//   Parameters
//     RAM_WIDTH   RAM data width (bits)
//     ADDR_WIDTH  RAM address width (bits)
// -----------------------------------------------------------------------------
interface rcb_host_arb_if #(
    parameter int RAM_WIDTH  = 64,
    parameter int ADDR_WIDTH = 14
);
    // Pipeline read channel
    logic                  pipe_req_valid;
    logic                  pipe_req_ready;
    logic [ADDR_WIDTH-1:0] pipe_req_addr;
    logic                  pipe_rsp_valid;
    logic [RAM_WIDTH-1:0]  pipe_rsp_data;

    // Host read/write channel
    logic                  host_req_valid;
    logic                  host_req_ready;
    logic                  host_req_wr;
    logic [ADDR_WIDTH-1:0] host_req_addr;
    logic [RAM_WIDTH-1:0]  host_req_wdata;
    logic                  host_rsp_valid;
    logic [RAM_WIDTH-1:0]  host_rsp_rdata;

    // Single-port RAM
    logic                  ram_en;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [RAM_WIDTH-1:0]  ram_wdata;
    logic [RAM_WIDTH-1:0]  ram_rdata;

    modport slave (
        input  pipe_req_valid, pipe_req_addr,
        input  host_req_valid, host_req_wr, host_req_addr, host_req_wdata,
        input  ram_rdata,
        output pipe_req_ready, pipe_rsp_valid, pipe_rsp_data,
        output host_req_ready, host_rsp_valid, host_rsp_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output pipe_req_valid, pipe_req_addr,
        output host_req_valid, host_req_wr, host_req_addr, host_req_wdata,
        output ram_rdata,
        input  pipe_req_ready, pipe_rsp_valid, pipe_rsp_data,
        input  host_req_ready, host_rsp_valid, host_rsp_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/rcb_host_arb.sv
// -----------------------------------------------------------------------------
// rcb_host_arb
//   Shares one single-port RCB RAM between the strategy lookup pipeline
//   (reads only, one per cycle) and the host register/table path (single
//   outstanding read or write). Every access is tagged at issue and the tag
//   travels alongside the RAM latency, so each read returns to the requester
//   that issued it, in issue order.
//
//   Ports
//     clk      core clock
//     reset_n  synchronous reset, active-low
//     arb_if   rcb_host_arb_if.slave: pipe/host request+response, RAM port
//
//   Parameters
//     RCB_HOST_ARB  0 = pipeline strict priority, 1 = round-robin pipe/host
//     RAM_WIDTH     RAM data width
//     ADDR_WIDTH    RAM address width
//     RAM_RD_LAT    ram_en to ram_rdata latency (1..4)
//     STARVE_LIMIT  consecutive pipe wins tolerated while the host waits
//
//   Optional feature macro
//     RCB_ARB_STARVE_GUARD_EN  adds the host anti-starvation counter
// -----------------------------------------------------------------------------
module rcb_host_arb #(
    parameter int RCB_HOST_ARB = 0,
    parameter int RAM_WIDTH    = 64,
    parameter int ADDR_WIDTH   = 14,
    parameter int RAM_RD_LAT   = 1,
    parameter int STARVE_LIMIT = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    rcb_host_arb_if.slave arb_if
);

    // One stage per cycle between issue and the rdata-capture edge.
    localparam int TAG_DEPTH = RAM_RD_LAT + 1;

    typedef enum logic {
        OWN_PIPE = 1'b0,
        OWN_HOST = 1'b1
    } owner_e;

    typedef struct packed {
        logic   vld;
        owner_e owner;
        logic   wr;
    } tag_t;

    tag_t [TAG_DEPTH-1:0]  tag_q;
    tag_t                  rsp_tag;

    logic                  host_busy_q, host_busy_d;
    logic                  rr_host_q, rr_host_d;   // 1: host wins next contested cycle
    logic                  host_elig, contested, grant_host;
    logic                  pipe_acc, host_acc;
    logic                  starve_hit;

    logic                  ram_en_q, ram_we_q;
    logic [ADDR_WIDTH-1:0] ram_addr_q;
    logic [RAM_WIDTH-1:0]  ram_wdata_q;
    logic                  pipe_rsp_valid_q, host_rsp_valid_q;
    logic [RAM_WIDTH-1:0]  pipe_rsp_data_q, host_rsp_rdata_q;

    assign rsp_tag = tag_q[TAG_DEPTH-1];

`ifdef RCB_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    assign starve_hit = (starve_cnt_q == CNT_W'(STARVE_LIMIT));

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!arb_if.host_req_valid || host_acc) begin
            starve_cnt_d = '0;
        end else if (pipe_acc && host_elig) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end
`else
    // Without the guard the host can be starved; the limit has no effect.
    logic unused_starve_limit;
    assign unused_starve_limit = (STARVE_LIMIT != 0);
    assign starve_hit          = 1'b0;
`endif

    // Grant selection. Readies are the grants themselves, gated by reset so
    // nothing is accepted (and every output reads 0) while reset_n is low.
    always_comb begin
        // NOTE: every signal assigned here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        grant_host = 1'b0;
        host_elig  = arb_if.host_req_valid & ~host_busy_q;
        contested  = arb_if.pipe_req_valid & host_elig;

        if (contested) begin
            if (starve_hit) begin
                grant_host = 1'b1;
            end else if (RCB_HOST_ARB != 0) begin
                grant_host = rr_host_q;
            end
        end else begin
            grant_host = host_elig;
        end

        host_acc = grant_host & reset_n;
        pipe_acc = arb_if.pipe_req_valid & ~grant_host & reset_n;

        // Pointer moves only when both sides actually competed.
        rr_host_d = rr_host_q;
        if (contested) begin
            rr_host_d = ~grant_host;
        end

        // Busy drops on the edge that launches the host response, so a new
        // host request can be accepted in the same cycle the response shows.
        host_busy_d = host_busy_q;
        if (host_acc) begin
            host_busy_d = 1'b1;
        end else if (rsp_tag.vld && rsp_tag.owner == OWN_HOST) begin
            host_busy_d = 1'b0;
        end
    end

    assign arb_if.pipe_req_ready = pipe_acc;
    assign arb_if.host_req_ready = host_acc;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // NOTE: the tag pipe is reset (unlike a data RAM) because its
            // valid bits decide whether a response fires; clearing it is what
            // drops in-flight reads.
            tag_q            <= '0;
            host_busy_q      <= 1'b0;
            rr_host_q        <= 1'b0;
            ram_en_q         <= 1'b0;
            ram_we_q         <= 1'b0;
            ram_addr_q       <= '0;
            ram_wdata_q      <= '0;
            pipe_rsp_valid_q <= 1'b0;
            pipe_rsp_data_q  <= '0;
            host_rsp_valid_q <= 1'b0;
            host_rsp_rdata_q <= '0;
`ifdef RCB_ARB_STARVE_GUARD_EN
            starve_cnt_q     <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // samples pre-edge values regardless of statement order.
            host_busy_q <= host_busy_d;
            rr_host_q   <= rr_host_d;
`ifdef RCB_ARB_STARVE_GUARD_EN
            starve_cnt_q <= starve_cnt_d;
`endif

            // Issue: address/data only load on a grant and hold when idle.
            ram_en_q <= pipe_acc | host_acc;
            ram_we_q <= host_acc & arb_if.host_req_wr;
            if (host_acc) begin
                ram_addr_q  <= arb_if.host_req_addr;
                ram_wdata_q <= arb_if.host_req_wdata;
            end else if (pipe_acc) begin
                ram_addr_q  <= arb_if.pipe_req_addr;
            end

            tag_q[0] <= '{vld:   pipe_acc | host_acc,
                          owner: host_acc ? OWN_HOST : OWN_PIPE,
                          wr:    host_acc & arb_if.host_req_wr};
            for (int i = 1; i < TAG_DEPTH; i++) begin
                tag_q[i] <= tag_q[i-1];
            end

            // Response: the last tag stage lines up with ram_rdata.
            pipe_rsp_valid_q <= rsp_tag.vld && rsp_tag.owner == OWN_PIPE;
            host_rsp_valid_q <= rsp_tag.vld && rsp_tag.owner == OWN_HOST;
            if (rsp_tag.vld && rsp_tag.owner == OWN_PIPE) begin
                pipe_rsp_data_q <= arb_if.ram_rdata;
            end
            if (rsp_tag.vld && rsp_tag.owner == OWN_HOST) begin
                host_rsp_rdata_q <= rsp_tag.wr ? '0 : arb_if.ram_rdata;
            end
        end
    end

    assign arb_if.ram_en         = ram_en_q;
    assign arb_if.ram_we         = ram_we_q;
    assign arb_if.ram_addr       = ram_addr_q;
    assign arb_if.ram_wdata      = ram_wdata_q;
    assign arb_if.pipe_rsp_valid = pipe_rsp_valid_q;
    assign arb_if.pipe_rsp_data  = pipe_rsp_data_q;
    assign arb_if.host_rsp_valid = host_rsp_valid_q;
    assign arb_if.host_rsp_rdata = host_rsp_rdata_q;

endmodule

// File: tb/tb_rcb_host_arb.sv
// -----------------------------------------------------------------------------
// tb_rcb_host_arb
//   Bench for rcb_host_arb. dut0 runs strict pipeline priority, dut1 runs
//   round-robin; both use RAM_RD_LAT=1 and a behavioural RAM each.
//   Honours RCB_ARB_STARVE_GUARD_EN when choosing contention expectations.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rcb_host_arb;

    localparam int AW = 14;
    localparam int DW = 64;
`ifdef RCB_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    rcb_host_arb_if #(.RAM_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
    rcb_host_arb_if #(.RAM_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();

    rcb_host_arb #(.RCB_HOST_ARB(0), .RAM_WIDTH(DW), .ADDR_WIDTH(AW),
                   .RAM_RD_LAT(1), .STARVE_LIMIT(16))
        dut0 (.clk(clk), .reset_n(reset_n), .arb_if(bus0.slave));

    rcb_host_arb #(.RCB_HOST_ARB(1), .RAM_WIDTH(DW), .ADDR_WIDTH(AW),
                   .RAM_RD_LAT(1), .STARVE_LIMIT(16))
        dut1 (.clk(clk), .reset_n(reset_n), .arb_if(bus1.slave));

    // Known RAM contents: each word carries its own address.
    function automatic logic [DW-1:0] pat(input int a);
        return 64'hC0DE_0000_0000_0000 | 64'(a);
    endfunction

    // Behavioural single-port RAMs, 1-cycle read latency.
    logic [DW-1:0] mem0 [0:(1<<AW)-1];
    logic [DW-1:0] mem1 [0:(1<<AW)-1];
    initial begin
        for (int a = 0; a < (1 << AW); a++) begin
            mem0[a] = pat(a);
            mem1[a] = pat(a);
        end
    end
    always @(posedge clk) begin
        if (bus0.ram_en && bus0.ram_we) mem0[bus0.ram_addr] <= bus0.ram_wdata;
        if (bus0.ram_en && !bus0.ram_we) bus0.ram_rdata <= mem0[bus0.ram_addr];
        if (bus1.ram_en && bus1.ram_we) mem1[bus1.ram_addr] <= bus1.ram_wdata;
        if (bus1.ram_en && !bus1.ram_we) bus1.ram_rdata <= mem1[bus1.ram_addr];
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive0(input logic pv, input logic [AW-1:0] pa, input logic hv,
                          input logic hw, input logic [AW-1:0] ha, input logic [DW-1:0] hd);
        bus0.pipe_req_valid = pv;
        bus0.pipe_req_addr  = pa;
        bus0.host_req_valid = hv;
        bus0.host_req_wr    = hw;
        bus0.host_req_addr  = ha;
        bus0.host_req_wdata = hd;
    endtask

    task automatic drive1(input logic pv, input logic [AW-1:0] pa, input logic hv,
                          input logic [AW-1:0] ha);
        bus1.pipe_req_valid = pv;
        bus1.pipe_req_addr  = pa;
        bus1.host_req_valid = hv;
        bus1.host_req_wr    = 1'b0;
        bus1.host_req_addr  = ha;
        bus1.host_req_wdata = '0;
    endtask

    // One cycle of dut0 stimulus plus the outputs expected in that cycle.
    typedef struct {
        logic          pv;
        logic [AW-1:0] pa;
        logic          hv;
        logic          hw;
        logic [AW-1:0] ha;
        logic [DW-1:0] hd;
        logic          x_pr, x_hr, x_en, x_we;
        logic [AW-1:0] x_addr;
        logic [DW-1:0] x_wd;
        logic          x_pvld;
        logic [DW-1:0] x_pdata;
        logic          x_hvld;
        logic [DW-1:0] x_hdata;
    } vec_t;

    function automatic vec_t mk(
        input logic pv, input logic [AW-1:0] pa, input logic hv, input logic hw,
        input logic [AW-1:0] ha, input logic [DW-1:0] hd,
        input logic x_pr, input logic x_hr, input logic x_en, input logic x_we,
        input logic [AW-1:0] x_addr, input logic [DW-1:0] x_wd,
        input logic x_pvld, input logic [DW-1:0] x_pdata,
        input logic x_hvld, input logic [DW-1:0] x_hdata);
        vec_t v;
        v.pv = pv;  v.pa = pa;  v.hv = hv;  v.hw = hw;  v.ha = ha;  v.hd = hd;
        v.x_pr = x_pr;  v.x_hr = x_hr;  v.x_en = x_en;  v.x_we = x_we;
        v.x_addr = x_addr;  v.x_wd = x_wd;
        v.x_pvld = x_pvld;  v.x_pdata = x_pdata;
        v.x_hvld = x_hvld;  v.x_hdata = x_hdata;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        // ---- vector table -------------------------------------------------
        // Pipe stream: reads of addr 0..7 in cycles 0..7; RAM issue in 1..8;
        // responses in 3..10 in address order.
        for (int i = 0; i < 12; i++) begin
            vecs.push_back(mk(i < 8, AW'(i), 1'b0, 1'b0, '0, '0,
                              i < 8, 1'b0, (i >= 1 && i <= 8), 1'b0, AW'(i - 1), '0,
                              (i >= 3 && i <= 10), pat(i - 3), 1'b0, '0));
        end
        // Host write 0x10=0xA5, then pipe read 0x10 sees the new data.
        vecs.push_back(mk(0, '0,    1, 1, 14'h10, 64'hA5, 0, 1, 0, 0, '0,     '0,     0, '0,     0, '0));
        vecs.push_back(mk(1, 14'h10, 0, 0, '0,    '0,     1, 0, 1, 1, 14'h10, 64'hA5, 0, '0,     0, '0));
        vecs.push_back(mk(0, '0,    0, 0, '0,    '0,     0, 0, 1, 0, 14'h10, '0,     0, '0,     0, '0));
        vecs.push_back(mk(0, '0,    0, 0, '0,    '0,     0, 0, 0, 0, '0,     '0,     0, '0,     1, '0));
        vecs.push_back(mk(0, '0,    0, 0, '0,    '0,     0, 0, 0, 0, '0,     '0,     1, 64'hA5, 0, '0));
        vecs.push_back(mk(0, '0,    0, 0, '0,    '0,     0, 0, 0, 0, '0,     '0,     0, '0,     0, '0));
        // Same-cycle pipe and host reads: pipe first, host next cycle.
        vecs.push_back(mk(1, 14'h3, 1, 0, 14'h20, '0, 1, 0, 0, 0, '0,     '0, 0, '0,     0, '0));
        vecs.push_back(mk(0, '0,    1, 0, 14'h20, '0, 0, 1, 1, 0, 14'h3,  '0, 0, '0,     0, '0));
        vecs.push_back(mk(0, '0,    0, 0, '0,     '0, 0, 0, 1, 0, 14'h20, '0, 0, '0,     0, '0));
        vecs.push_back(mk(0, '0,    0, 0, '0,     '0, 0, 0, 0, 0, '0,     '0, 1, pat(3), 0, '0));
        vecs.push_back(mk(0, '0,    0, 0, '0,     '0, 0, 0, 0, 0, '0,     '0, 0, '0,     1, pat(32)));
        vecs.push_back(mk(0, '0,    0, 0, '0,     '0, 0, 0, 0, 0, '0,     '0, 0, '0,     0, '0));

        // ---- 1: reset with requests active ---------------------------------
        reset_n = 1'b0;
        drive0(1'b1, 14'h7, 1'b1, 1'b1, 14'h9, 64'hFF);
        drive1(1'b1, 14'h7, 1'b1, 14'h9);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst pipe_ready", bus0.pipe_req_ready, 0);
        check("rst host_ready", bus0.host_req_ready, 0);
        check("rst ram_en",     bus0.ram_en,         0);
        check("rst ram_we",     bus0.ram_we,         0);
        check("rst ram_addr",   bus0.ram_addr,       0);
        check("rst ram_wdata",  bus0.ram_wdata,      0);
        check("rst pipe_rsp_v", bus0.pipe_rsp_valid, 0);
        check("rst pipe_rsp_d", bus0.pipe_rsp_data,  0);
        check("rst host_rsp_v", bus0.host_rsp_valid, 0);
        check("rst host_rsp_d", bus0.host_rsp_rdata, 0);
        check("rst rr pipe_ready", bus1.pipe_req_ready, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        drive0(0, '0, 0, 0, '0, '0);
        drive1(0, '0, 0, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("idle%0d ram_en", i), bus0.ram_en, 0);
            @(posedge clk); #1;
        end

        // ---- 2/3 and same-cycle contention: table ---------------------------
        foreach (vecs[i]) begin
            drive0(vecs[i].pv, vecs[i].pa, vecs[i].hv, vecs[i].hw, vecs[i].ha, vecs[i].hd);
            @(negedge clk);
            check($sformatf("v%0d pipe_ready", i), bus0.pipe_req_ready, vecs[i].x_pr);
            check($sformatf("v%0d host_ready", i), bus0.host_req_ready, vecs[i].x_hr);
            check($sformatf("v%0d ram_en", i),     bus0.ram_en,         vecs[i].x_en);
            check($sformatf("v%0d ram_we", i),     bus0.ram_we,         vecs[i].x_we);
            if (vecs[i].x_en)
                check($sformatf("v%0d ram_addr", i),  bus0.ram_addr,  vecs[i].x_addr);
            if (vecs[i].x_we)
                check($sformatf("v%0d ram_wdata", i), bus0.ram_wdata, vecs[i].x_wd);
            check($sformatf("v%0d pipe_rsp_v", i), bus0.pipe_rsp_valid, vecs[i].x_pvld);
            if (vecs[i].x_pvld)
                check($sformatf("v%0d pipe_rsp_d", i), bus0.pipe_rsp_data, vecs[i].x_pdata);
            check($sformatf("v%0d host_rsp_v", i), bus0.host_rsp_valid, vecs[i].x_hvld);
            if (vecs[i].x_hvld)
                check($sformatf("v%0d host_rsp_d", i), bus0.host_rsp_rdata, vecs[i].x_hdata);
            @(posedge clk); #1;
        end

        // ---- 4: strict priority, continuous pipe traffic --------------------
        // Host is shut out for 40 cycles, or wins contested cycle 17 with the
        // starvation guard built in.
        for (int i = 0; i < 40; i++) begin
            drive0(1'b1, AW'(i), 1'b1, 1'b0, 14'h40, '0);
            @(negedge clk);
            check($sformatf("starve%0d host_ready", i), bus0.host_req_ready, GUARD && i == 16);
            check($sformatf("starve%0d pipe_ready", i), bus0.pipe_req_ready, !(GUARD && i == 16));
            @(posedge clk); #1;
            if (GUARD && i == 16) break;
        end
        drive0(0, '0, 0, 0, '0, '0);
        repeat (6) @(posedge clk);
        #1;

        // ---- 5: round-robin, both always requesting (dut1) -----------------
        // Host accepted at cycle 1, busy until its response at cycle 4, so
        // host wins every 4th cycle and pipe all others.
        for (int i = 0; i < 20; i++) begin
            drive1(1'b1, AW'(i), 1'b1, 14'h40);
            @(negedge clk);
            check($sformatf("rr%0d host_ready", i), bus1.host_req_ready, (i % 4) == 1);
            check($sformatf("rr%0d pipe_ready", i), bus1.pipe_req_ready, (i % 4) != 1);
            @(posedge clk); #1;
        end
        drive1(0, '0, 0, '0);
        repeat (6) @(posedge clk);
        #1;

        // ---- 6: reset one cycle after three pipe accepts --------------------
        for (int i = 0; i < 3; i++) begin
            drive0(1'b1, AW'(i + 1), 1'b0, 1'b0, '0, '0);
            @(negedge clk);
            check($sformatf("mid%0d pipe_ready", i), bus0.pipe_req_ready, 1);
            @(posedge clk); #1;
        end
        drive0(0, '0, 0, 0, '0, '0);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid pre-reset rsp_v", bus0.pipe_rsp_valid, 1);
        check("mid pre-reset rsp_d", bus0.pipe_rsp_data, pat(1));
        @(posedge clk); #1;
        @(negedge clk);
        check("mid in-reset rsp_v", bus0.pipe_rsp_valid, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("mid post%0d rsp_v", i), bus0.pipe_rsp_valid, 0);
            check($sformatf("mid post%0d ram_en", i), bus0.ram_en, 0);
            @(posedge clk); #1;
        end
        drive0(1'b1, 14'h5, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("after pipe_ready", bus0.pipe_req_ready, 1);
        @(posedge clk); #1;
        drive0(0, '0, 0, 0, '0, '0);
        @(negedge clk);
        check("after ram_en", bus0.ram_en, 1);
        check("after ram_addr", bus0.ram_addr, 14'h5);
        @(posedge clk); #1;
        @(negedge clk);
        check("after early rsp_v", bus0.pipe_rsp_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("after rsp_v", bus0.pipe_rsp_valid, 1);
        check("after rsp_d", bus0.pipe_rsp_data, pat(5));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
